vga_text_writer: RTL and testbench
==================================

Name: vga_text_writer

Overview:
Upstream feeder of the VGA text-mode video RAM. It accepts a character byte stream over a valid/ready handshake and interprets control codes. It keeps a cursor on an 80x60 character grid and emits registered single-byte writes (addr/data/we) straight into the VRAM write port. Clear-screen and line-wrap clearing run as internal fill sequences that back-pressure the stream.

Parameters:
COLS, 80, characters per row
ROWS, 60, rows per screen; COLS*ROWS must be <= 6144
FILL_CHAR, 8'h20, byte written by clear operations

Ports:
clk  in  1  system clock (100 MHz domain, same as VRAM)
rst  in  1  asynchronous active-low reset
ch_data  in  8  character or control byte
ch_valid  in  1  ch_data valid
ch_ready  out  1  block accepts ch_data this cycle (transfer = ch_valid & ch_ready)
vmem_in_addr  out  13  VRAM write address = row*COLS + col
vmem_in_data  out  8  VRAM write data
vmem_we  out  1  VRAM write strobe, one cycle per byte
cur_col  out  7  cursor column, 0..COLS-1
cur_row  out  6  cursor row, 0..ROWS-1
busy  out  1  high while a fill sequence runs

Behaviour:
- Reset (rst low, asynchronous): vmem_we=0, vmem_in_addr=0, vmem_in_data=0, cur_col=0, cur_row=0, ch_ready=0, busy=1, state=CLR_SCREEN, fill pointer=0. On release the full-screen clear runs automatically.
- States: IDLE, CLR_SCREEN, CLR_LINE. ch_ready = (state==IDLE), driven from a register. busy = (state!=IDLE).
- IDLE, on a transfer, with writes registered one cycle after the transfer:
  - printable (8'h20..8'h7E, 8'h80..8'hFF): write ch_data at the cursor, then advance col. If col==COLS-1, set col=0 and go to the next row.
  - 8'h0A LF: col=0, next row. No write.
  - 8'h0D CR: col=0. No write.
  - 8'h08 BS: if col>0, col-=1 and write FILL_CHAR at the new position. At col==0, no action.
  - 8'h0C FF: cursor=(0,0), enter CLR_SCREEN.
  - other codes 8'h00..8'h1F and 8'h7F: ignored, consumed, no write.
- Next row: if row<ROWS-1, row+=1. Otherwise row=0. In both cases enter CLR_LINE for the new row (the screen wraps to top, no scroll).
- CLR_SCREEN: writes FILL_CHAR at addresses 0..COLS*ROWS-1, one per cycle, then returns to IDLE. Exactly COLS*ROWS we pulses.
- CLR_LINE: writes FILL_CHAR at row_base..row_base+COLS-1, one per cycle (COLS pulses), then returns to IDLE.
- Address arithmetic: no multiplier. A row_base register tracks row*COLS; it adds COLS on next row and is set to 0 on wrap/FF. The address is row_base+col, computed at 13 bits.
- Latency: transfer at cycle N gives vmem_we at N+1. The cursor update is visible at N+1. ch_ready falls at N+1 if a fill starts.
- Throughput: one printable char per cycle in IDLE.
- A transfer at the last column of the last row writes the char, then wraps to (0,0) and clears row 0.
- ch_valid while ch_ready=0 is held off; ch_data must be stable until accepted (upstream rule).
- Reset asserted mid-fill aborts immediately and restarts CLR_SCREEN after release.

Decomposition:
- Shared package vga_text_pkg holds COLS/ROWS defaults, control-code constants (CC_LF, CC_CR, CC_BS, CC_FF), FILL_CHAR, and the state enum.
- One natural sub-module: vga_text_cursor. It holds col/row/row_base with advance, newline, back, and home commands, and produces the address.
- The top level holds the FSM, the fill counter, and the output registers.

Test Plan:
- Reset release -> 4800 we pulses, addr 0..4799, data 8'h20; then ch_ready=1 and cursor (0,0).
- Send "AB" back-to-back -> writes (0,8'h41),(1,8'h42) on consecutive cycles; cur_col=2.
- Cursor at (79,0), send 8'h43 -> write addr 79. Cursor becomes (0,1), then CLR_LINE writes addr 80..159 and ch_ready stays low for 80 cycles.
- Cursor at (5,59), send 8'h0A -> no char write, cursor (0,0), CLR_LINE over addr 0..79.
- Cursor (3,2): send 8'h08 -> write (162,8'h20), cursor (2,2). Send 8'h0D -> cursor (0,2). Send 8'h08 -> no write. Send 8'h07 -> consumed, no write.
- Send 8'h0C, then assert rst at fill index 1000 and release -> CLR_SCREEN restarts at addr 0 with full 4800 writes.

Source files
------------

// File: rtl/vga_text_pkg.sv
// -----------------------------------------------------------------------------
// vga_text_pkg
// Shared definitions for the VGA text writer: screen geometry defaults,
// control-code values, the fill byte, FSM state encodings and the
// printable-byte classifier.
// -----------------------------------------------------------------------------
package vga_text_pkg;

   localparam int COLS_DEF = 80;
   localparam int ROWS_DEF = 60;

   localparam logic [7:0] FILL_CHAR_DEF = 8'h20;

   // Control codes acted on by the writer; every other byte below 8'h20
   // (and 8'h7F) is consumed without effect.
   localparam logic [7:0] CC_LF  = 8'h0A;
   localparam logic [7:0] CC_CR  = 8'h0D;
   localparam logic [7:0] CC_BS  = 8'h08;
   localparam logic [7:0] CC_FF  = 8'h0C;
   localparam logic [7:0] CC_DEL = 8'h7F;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_CLR_SCREEN = 2'd1;
   localparam logic [1:0] ST_CLR_LINE   = 2'd2;

   // Printable = 8'h20..8'h7E and 8'h80..8'hFF
   function automatic logic is_printable(input logic [7:0] b);
      return (b >= 8'h20) && (b != CC_DEL);
   endfunction

endpackage

// File: rtl/vga_text_cursor.sv
// -----------------------------------------------------------------------------
// vga_text_cursor
// Cursor position on the character grid plus the row base (row*COLS) kept
// incrementally so the VRAM address needs only an adder.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   i_advance      : move one column right, stepping to the next row at EOL
//   i_newline      : column 0 of the next row
//   i_cr           : column 0 of the current row
//   i_back         : move one column left (caller guarantees col > 0)
//   i_home         : cursor to (0,0)
//   o_col, o_row   : cursor position
//   o_row_base     : row*COLS for the current row
//   o_addr         : row_base + col
//   o_at_eol       : cursor is in the last column
//   o_at_bol       : cursor is in column 0
// -----------------------------------------------------------------------------
module vga_text_cursor
   import vga_text_pkg::*;
#(
   parameter int COLS = COLS_DEF,
   parameter int ROWS = ROWS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_advance,
   input  logic        i_newline,
   input  logic        i_cr,
   input  logic        i_back,
   input  logic        i_home,
   output logic [6:0]  o_col,
   output logic [5:0]  o_row,
   output logic [12:0] o_row_base,
   output logic [12:0] o_addr,
   output logic        o_at_eol,
   output logic        o_at_bol
);

   localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
   localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);
   localparam logic [12:0] ROW_STEP = 13'(COLS);

   logic [6:0]  r_col;
   logic [5:0]  r_row;
   logic [12:0] r_row_base;
   logic        w_next_row;

   assign o_at_eol   = (r_col == LAST_COL);
   assign o_at_bol   = (r_col == 7'd0);
   assign w_next_row = i_newline | (i_advance & o_at_eol);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col      <= '0;
         r_row      <= '0;
         r_row_base <= '0;
      end else if (i_home) begin
         r_col      <= '0;
         r_row      <= '0;
         r_row_base <= '0;
      end else if (w_next_row) begin
         r_col <= '0;
         // The screen wraps to the top instead of scrolling.
         if (r_row == LAST_ROW) begin
            r_row      <= '0;
            r_row_base <= '0;
         end else begin
            r_row      <= r_row + 6'd1;
            r_row_base <= r_row_base + ROW_STEP;
         end
      end else if (i_advance) begin
         r_col <= r_col + 7'd1;
      end else if (i_back) begin
         r_col <= r_col - 7'd1;
      end else if (i_cr) begin
         r_col <= '0;
      end
   end

   assign o_col      = r_col;
   assign o_row      = r_row;
   assign o_row_base = r_row_base;
   assign o_addr     = r_row_base + {6'd0, r_col};

endmodule

// File: rtl/vga_text_writer.sv
// -----------------------------------------------------------------------------
// vga_text_writer
// Turns a character byte stream into single-byte VRAM writes, interpreting
// LF/CR/BS/FF, and runs screen/line clear fills that stall the stream.
// Handshake: a byte transfers on a rising edge where ch_valid & ch_ready;
// ch_ready is registered and high only in IDLE; ch_data must stay stable
// while ch_valid is held off.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   ch_data/valid   : input byte stream, ch_ready back-pressure
//   vmem_in_addr    : VRAM write address (row*COLS + col)
//   vmem_in_data    : VRAM write data
//   vmem_we         : VRAM write strobe, one cycle per byte
//   cur_col/cur_row : cursor position
//   busy            : a fill sequence is running (state != IDLE)
// -----------------------------------------------------------------------------
module vga_text_writer
   import vga_text_pkg::*;
#(
   parameter int         COLS      = COLS_DEF,
   parameter int         ROWS      = ROWS_DEF,
   parameter logic [7:0] FILL_CHAR = FILL_CHAR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  ch_data,
   input  logic        ch_valid,
   output logic        ch_ready,
   output logic [12:0] vmem_in_addr,
   output logic [7:0]  vmem_in_data,
   output logic        vmem_we,
   output logic [6:0]  cur_col,
   output logic [5:0]  cur_row,
   output logic        busy
);

   localparam logic [12:0] LAST_SCREEN = 13'(COLS * ROWS - 1);
   localparam logic [12:0] LAST_LINE   = 13'(COLS - 1);

   logic [1:0]  r_state;
   logic [12:0] r_fill;
   logic        r_ready;
   logic        r_we;
   logic [12:0] r_addr;
   logic [7:0]  r_data;

   logic        w_xfer;
   logic        w_advance, w_newline, w_cr, w_back, w_home, w_row_step;
   logic [12:0] w_addr, w_row_base;
   logic        w_at_eol, w_at_bol;

   // r_ready is only ever high in IDLE, so a transfer implies IDLE.
   assign w_xfer = ch_valid & r_ready;

   always_comb begin
      w_advance = 1'b0;
      w_newline = 1'b0;
      w_cr      = 1'b0;
      w_back    = 1'b0;
      w_home    = 1'b0;
      if (w_xfer) begin
         if (is_printable(ch_data)) begin
            w_advance = 1'b1;
         end else begin
            case (ch_data)
               CC_LF:   w_newline = 1'b1;
               CC_CR:   w_cr      = 1'b1;
               CC_BS:   w_back    = !w_at_bol;
               CC_FF:   w_home    = 1'b1;
               default: ;
            endcase
         end
      end
   end

   assign w_row_step = w_newline | (w_advance & w_at_eol);

   vga_text_cursor #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_cursor (
      .clk        (clk),
      .rst        (rst),
      .i_advance  (w_advance),
      .i_newline  (w_newline),
      .i_cr       (w_cr),
      .i_back     (w_back),
      .i_home     (w_home),
      .o_col      (cur_col),
      .o_row      (cur_row),
      .o_row_base (w_row_base),
      .o_addr     (w_addr),
      .o_at_eol   (w_at_eol),
      .o_at_bol   (w_at_bol)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_CLR_SCREEN;
         r_fill  <= '0;
         r_ready <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_advance) begin
                  r_we   <= 1'b1;
                  r_addr <= w_addr;
                  r_data <= ch_data;
               end
               // Blank the cell the cursor moves back onto.
               if (w_back) begin
                  r_we   <= 1'b1;
                  r_addr <= w_addr - 13'd1;
                  r_data <= FILL_CHAR;
               end
               if (w_row_step) begin
                  r_state <= ST_CLR_LINE;
                  r_fill  <= '0;
                  r_ready <= 1'b0;
               end
               if (w_home) begin
                  r_state <= ST_CLR_SCREEN;
                  r_fill  <= '0;
                  r_ready <= 1'b0;
               end
            end
            ST_CLR_SCREEN: begin
               r_we   <= 1'b1;
               r_addr <= r_fill;
               r_data <= FILL_CHAR;
               if (r_fill == LAST_SCREEN) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_fill <= r_fill + 13'd1;
               end
            end
            ST_CLR_LINE: begin
               // The cursor already points at the new row, so its base is
               // the start of the line being cleared.
               r_we   <= 1'b1;
               r_addr <= w_row_base + r_fill;
               r_data <= FILL_CHAR;
               if (r_fill == LAST_LINE) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_fill <= r_fill + 13'd1;
               end
            end
            default: begin
               r_state <= ST_CLR_SCREEN;
               r_fill  <= '0;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign ch_ready     = r_ready;
   assign busy         = (r_state != ST_IDLE);
   assign vmem_we      = r_we;
   assign vmem_in_addr = r_addr;
   assign vmem_in_data = r_data;

endmodule

// File: tb/tb_vga_text_writer.sv
// -----------------------------------------------------------------------------
// tb_vga_text_writer
// Bench for vga_text_writer: a behavioural cursor model pushes every expected
// VRAM write into exp_q as bytes are driven; a monitor pops and compares each
// observed write. Cursor, ready and strobe timing are checked one cycle after
// every transfer.
// -----------------------------------------------------------------------------
module tb_vga_text_writer;
   import vga_text_pkg::*;

   localparam int COLS = 80;
   localparam int ROWS = 60;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  ch_data = 8'h00;
   logic        ch_valid = 1'b0;
   logic        ch_ready;
   logic [12:0] vmem_in_addr;
   logic [7:0]  vmem_in_data;
   logic        vmem_we;
   logic [6:0]  cur_col;
   logic [5:0]  cur_row;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   int n_wr     = 0;
   int m_col    = 0;
   int m_row    = 0;

   logic [20:0] exp_q[$];   // {addr, data}

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   vga_text_writer dut (
      .clk          (clk),
      .rst          (rst),
      .ch_data      (ch_data),
      .ch_valid     (ch_valid),
      .ch_ready     (ch_ready),
      .vmem_in_addr (vmem_in_addr),
      .vmem_in_data (vmem_in_data),
      .vmem_we      (vmem_we),
      .cur_col      (cur_col),
      .cur_row      (cur_row),
      .busy         (busy)
   );

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [20:0] e;
      if (vmem_we === 1'b1) begin
         n_wr++;
         if (exp_q.size() == 0) begin
            chk("unexpected_we", 32'({vmem_in_addr, vmem_in_data}), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("vram_write", 32'({vmem_in_addr, vmem_in_data}), 32'(e));
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [20:0] ent(input int row, input int col, input logic [7:0] d);
      return {13'(row * COLS + col), d};
   endfunction

   task automatic push_screen();
      for (int i = 0; i < COLS * ROWS; i++) exp_q.push_back({13'(i), 8'h20});
   endtask

   task automatic push_line();
      for (int i = 0; i < COLS; i++) exp_q.push_back(ent(m_row, i, 8'h20));
   endtask

   task automatic model_next_row();
      m_col = 0;
      m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
      push_line();
   endtask

   task automatic model_byte(input logic [7:0] b, output logic e_we, output logic e_fill);
      e_we   = 1'b0;
      e_fill = 1'b0;
      if ((b >= 8'h20) && (b != 8'h7F)) begin
         exp_q.push_back(ent(m_row, m_col, b));
         e_we = 1'b1;
         if (m_col == COLS - 1) begin
            model_next_row();
            e_fill = 1'b1;
         end else begin
            m_col++;
         end
      end else if (b == 8'h0A) begin
         model_next_row();
         e_fill = 1'b1;
      end else if (b == 8'h0D) begin
         m_col = 0;
      end else if (b == 8'h08) begin
         if (m_col > 0) begin
            m_col--;
            exp_q.push_back(ent(m_row, m_col, 8'h20));
            e_we = 1'b1;
         end
      end else if (b == 8'h0C) begin
         m_col = 0;
         m_row = 0;
         push_screen();
         e_fill = 1'b1;
      end
   endtask

   function automatic logic [7:0] rand_print();
      if ($urandom_range(0, 1) == 0) return 8'($urandom_range(32, 126));
      else                           return 8'($urandom_range(128, 255));
   endfunction

   // ---------------- driver tasks (called at a falling edge) ----------------
   task automatic send_byte(input logic [7:0] b);
      logic e_we, e_fill;
      int   guard;
      guard    = 0;
      ch_data  = b;
      ch_valid = 1'b1;
      while (ch_ready !== 1'b1 && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (ch_ready !== 1'b1) begin
         chk("send_timeout", 32'(ch_ready), 32'd1);
         ch_valid = 1'b0;
         return;
      end
      model_byte(b, e_we, e_fill);
      @(negedge clk);
      ch_valid = 1'b0;
      chk("cur_col", 32'(cur_col), 32'(m_col));
      chk("cur_row", 32'(cur_row), 32'(m_row));
      chk("we_after_xfer", 32'(vmem_we), 32'(e_we));
      chk("ready_after_xfer", 32'(ch_ready), 32'(!e_fill));
      chk("busy_after_xfer", 32'(busy), 32'(e_fill));
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (ch_ready !== 1'b1 && cnt < 20000) begin
         @(negedge clk);
         cnt++;
      end
      if (ch_ready !== 1'b1) chk("ready_timeout", 32'(ch_ready), 32'd1);
   endtask

   task automatic drain_check(input string tag);
      repeat (2) @(negedge clk);
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          cnt;
      int          base;
      logic [7:0]  mix [12];

      mix = '{8'h41, 8'h7F, 8'h1B, 8'h00, 8'hC8, 8'h0D, 8'h7E, 8'h20,
              8'h08, 8'h08, 8'h80, 8'h1F};

      // Reset values while held in reset.
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_we",    32'(vmem_we),      32'd0);
      chk("rst_addr",  32'(vmem_in_addr), 32'd0);
      chk("rst_data",  32'(vmem_in_data), 32'd0);
      chk("rst_ready", 32'(ch_ready),     32'd0);
      chk("rst_busy",  32'(busy),         32'd1);
      chk("rst_col",   32'(cur_col),      32'd0);
      chk("rst_row",   32'(cur_row),      32'd0);

      // Boot clear: full screen of fill bytes.
      push_screen();
      rst = 1'b1;
      wait_ready(cnt);
      chk("boot_clear_cycles", 32'(cnt), 32'(COLS * ROWS));
      drain_check("boot_clear_drain");
      chk("boot_col", 32'(cur_col), 32'd0);
      chk("boot_row", 32'(cur_row), 32'd0);

      // "AB" back to back.
      send_byte(8'h41);
      send_byte(8'h42);
      chk("ab_col", 32'(cur_col), 32'd2);

      // CR, then fill row 0 up to column 79 and cross the line end.
      send_byte(8'h0D);
      for (int i = 0; i < COLS - 1; i++) send_byte(rand_print());
      chk("eol_col", 32'(cur_col), 32'(COLS - 1));
      send_byte(8'h43);
      wait_ready(cnt);
      chk("line_clear_cycles", 32'(cnt), 32'(COLS));
      drain_check("line_clear_drain");

      // Walk down to the last row, then LF at (5,59) wraps to row 0.
      for (int i = 0; i < ROWS - 2; i++) send_byte(8'h0A);
      chk("last_row", 32'(cur_row), 32'(ROWS - 1));
      for (int i = 0; i < 5; i++) send_byte(rand_print());
      send_byte(8'h0A);
      wait_ready(cnt);
      drain_check("wrap_clear_drain");

      // Backspace / CR / ignored code at (3,2).
      send_byte(8'h0A);
      send_byte(8'h0A);
      for (int i = 0; i < 3; i++) send_byte(rand_print());
      send_byte(8'h08);
      send_byte(8'h0D);
      send_byte(8'h08);
      send_byte(8'h07);
      drain_check("bs_cr_drain");

      // Mixed printable/control stream.
      foreach (mix[i]) send_byte(mix[i]);
      drain_check("mix_drain");

      // Form feed, then reset in the middle of the screen fill.
      send_byte(8'h0C);
      base = n_wr;
      cnt  = 0;
      while ((n_wr - base) < 1000 && cnt < 20000) begin
         @(negedge clk);
         cnt++;
      end
      chk("ff_fill_progress", 32'((n_wr - base) >= 1000), 32'd1);
      rst = 1'b0;
      #1;
      exp_q.delete();
      m_col = 0;
      m_row = 0;
      @(negedge clk);
      chk("midrst_we",    32'(vmem_we),      32'd0);
      chk("midrst_addr",  32'(vmem_in_addr), 32'd0);
      chk("midrst_ready", 32'(ch_ready),     32'd0);
      chk("midrst_busy",  32'(busy),         32'd1);
      push_screen();
      base = n_wr;
      rst  = 1'b1;
      wait_ready(cnt);
      chk("restart_clear_cycles", 32'(cnt), 32'(COLS * ROWS));
      drain_check("restart_clear_drain");
      chk("restart_writes", 32'(n_wr - base), 32'(COLS * ROWS));

      // Normal operation resumes at (0,0).
      send_byte(8'h5A);
      drain_check("final_drain");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Watchdog
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete (errors=%0d checks=%0d)", n_errors, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
